// File: rtl/osc_trigger_capture.sv
// Oscilloscope trigger and frame capture: decimates ADC samples, arms on
// request, triggers on a level crossing or auto timeout, delivers one frame.
module osc_trigger_capture #(
  parameter int VAL_RES      = 16,
  parameter int NPOINTS      = 640,
  parameter int AUTO_TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [VAL_RES-1:0] sample,
  input  logic               sample_valid,
  input  logic               enable,
  input  logic [VAL_RES-1:0] trig_level,
  input  logic               trig_falling,
  input  logic               trig_auto,
  input  logic [7:0]         decim,
  input  logic               frame_req,
  output logic [VAL_RES-1:0] val,
  output logic               readValEn,
  output logic               armed,
  output logic               triggered,
  output logic               forced
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_TRIG,
    CAPTURE,
    DONE
  } state_t;

  localparam int PW = $clog2(NPOINTS + 1);
  localparam int TW = $clog2(AUTO_TIMEOUT + 1);
  localparam logic [PW-1:0] P_LAST = PW'(NPOINTS - 1);
  localparam logic [TW-1:0] T_LAST = TW'(AUTO_TIMEOUT - 1);

  state_t             state, state_nx;
  logic [7:0]         dcnt, dcnt_nx;
  logic [TW-1:0]      tcnt, tcnt_nx;
  logic [PW-1:0]      pcnt, pcnt_nx;
  logic [VAL_RES-1:0] prev, prev_nx;
  logic [VAL_RES-1:0] val_nx;
  logic               prev_ok, prev_ok_nx;
  logic               rve_nx, forced_nx;
  logic               dsample, rise, fall, hit, timeout;

  assign dsample = sample_valid && (dcnt == 8'd0);
  assign rise    = prev_ok && (prev < trig_level)
                && (sample >= trig_level);
  assign fall    = prev_ok && (prev > trig_level)
                && (sample <= trig_level);
  assign hit     = dsample && (trig_falling ? fall : rise);
  // an edge on the same dsample wins over the timeout
  assign timeout = dsample && trig_auto && !hit
                && (tcnt == T_LAST);

  assign armed     = (state == WAIT_TRIG);
  assign triggered = (state == CAPTURE) || (state == DONE);

  always_comb begin
    state_nx   = state;
    dcnt_nx    = dcnt;
    tcnt_nx    = tcnt;
    pcnt_nx    = pcnt;
    prev_nx    = prev;
    prev_ok_nx = prev_ok;
    val_nx     = val;
    rve_nx     = 1'b0;
    forced_nx  = forced;

    if (sample_valid)
      dcnt_nx = (dcnt >= decim) ? 8'd0 : dcnt + 8'd1;
    if (dsample) begin
      prev_nx    = sample;
      prev_ok_nx = 1'b1;
    end

    case (state)
      IDLE: begin
        state_nx   = WAIT_TRIG;
        tcnt_nx    = '0;
        prev_ok_nx = 1'b0;
      end
      WAIT_TRIG: begin
        if (hit || timeout) begin
          state_nx  = (P_LAST == '0) ? DONE : CAPTURE;
          val_nx    = sample;
          rve_nx    = 1'b1;
          pcnt_nx   = PW'(1);
          forced_nx = timeout;
        end else if (dsample && tcnt != T_LAST) begin
          tcnt_nx = tcnt + TW'(1);
        end
      end
      CAPTURE: begin
        if (dsample) begin
          val_nx  = sample;
          rve_nx  = 1'b1;
          pcnt_nx = pcnt + PW'(1);
          if (pcnt == P_LAST)
            state_nx = DONE;
        end
      end
      DONE: begin
        if (frame_req) begin
          state_nx   = WAIT_TRIG;
          tcnt_nx    = '0;
          pcnt_nx    = '0;
          prev_ok_nx = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase

    // stop abandons any partial frame
    if (!enable) begin
      state_nx   = IDLE;
      dcnt_nx    = 8'd0;
      tcnt_nx    = '0;
      pcnt_nx    = '0;
      prev_ok_nx = 1'b0;
      val_nx     = val;
      rve_nx     = 1'b0;
      forced_nx  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dcnt      <= 8'd0;
      tcnt      <= '0;
      pcnt      <= '0;
      prev      <= '0;
      prev_ok   <= 1'b0;
      val       <= '0;
      readValEn <= 1'b0;
      forced    <= 1'b0;
    end else begin
      state     <= state_nx;
      dcnt      <= dcnt_nx;
      tcnt      <= tcnt_nx;
      pcnt      <= pcnt_nx;
      prev      <= prev_nx;
      prev_ok   <= prev_ok_nx;
      val       <= val_nx;
      readValEn <= rve_nx;
      forced    <= forced_nx;
    end
  end

endmodule
